oka_seq_mult: RTL and testbench
===============================

Name: oka_seq_mult

Overview:
- Parametrised, time-multiplexed overlap-free Karatsuba GF(2) polynomial multiplier. Computes the carry-less product y = a·b over GF(2)[x] for N-bit operands.
- Uses one shared half-width combinational sub-multiplier, issued three times over consecutive cycles.
- Sits in the binary-field datapath, for example the 193-bit ECC multiplier, where area matters more than single-cycle latency.
- Valid/ready handshakes on input and output.

Parameters:
- N, 13, operand width in bits; legal range N >= 2, odd or even.
- H, (N+1)/2, derived half width: sub-multiplier operand width. Not to be overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a and b are valid.
- in_ready  output  1  block can accept operands.
- a  input  N  operand A; bit i is the coefficient of x^i.
- b  input  N  operand B.
- out_valid  output  1  y holds a completed product.
- out_ready  input  1  consumer accepts y.
- y  output  2N-1  carry-less product a·b.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, out_valid=0, y=0, internal operand and partial-product registers=0. Reset mid-operation aborts the product silently; nothing is emitted.
- Operand split: ae = even-index bits of a, H bits. ao = odd-index bits of a, N/2 bits, zero-padded at the MSB to H bits. be and bo are formed the same way from b. am = ae^ao and bm = be^bo.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, register ae, ao, be, bo and go to S_E. Later changes on a and b are ignored.
  - S_E: Pe = ae·be (2H-1 bits) is registered; go to S_O.
  - S_O: Po = ao·bo is registered; go to S_M.
  - S_M: Pm = am·bm; y is registered with the recombination below; go to DONE.
  - DONE: out_valid=1 and y is held stable. On out_ready, go to IDLE.
- Fast path: in DONE, in_ready = out_ready. A new operand pair accepted in the same cycle as the output handshake goes directly to S_E. Sustained throughput is therefore one product per 4 cycles.
- Sub-multiplier operand mux is selected by state: {ae,be} in S_E, {ao,bo} in S_O, {am,bm} in S_M.
- Recombination:
  - spread(p) places p[i] at bit 2i, with zeros at odd positions.
  - y = ( spread(Pe) ^ (spread(Po)<<2) ^ (spread(Pm^Pe^Po)<<1) ) truncated to 2N-1 bits.
  - For odd N the truncated bits are provably zero. Assertion: no 1 is dropped.
- Latency: accept edge at cycle t; out_valid=1 from cycle t+4.
- in_valid while in S_E, S_O or S_M: in_ready=0, no capture, no effect.
- out_valid falls the cycle after the handshake unless the fast path re-enters DONE.
- out_ready held high continuously: one product per 4 cycles.
- out_ready held low: DONE is held indefinitely and y does not change.

Decomposition:
- Shared package oka_pkg:
  - function spread(p) (generic via width parameter);
  - function oka_half(N) returning (N+1)/2;
  - state enum type oka_state_t {IDLE, S_E, S_O, S_M, DONE}.
- One sub-module: gf2_poly_mul_comb, parameter W. Combinational schoolbook carry-less multiplier, W×W → 2W-1 bits. Instantiated once with W=H.
- Later generations may replace it with a recursive OKA core behind the same interface.

Test Plan:
- N=13, a=13'h0001, b=13'h0001, out_ready=1 -> y=25'h0000001, out_valid at t+4, in_ready low during S_E..S_M.
- N=13, a=b=13'h0003 -> y=25'h0000005; a=b=13'h1FFF -> y=25'h1555555; a=b=13'h1000 -> y=25'h1000000.
- N=13, a=13'h1FFF, b=13'h0001 with out_ready=0 for 10 cycles -> y=25'h0001FFF held stable and out_valid=1 throughout. a and b toggled during the stall have no effect.
- Back-to-back with in_valid=1 and out_ready=1 -> accepts every 4 cycles via the DONE fast path; results in order. Random 1000 pairs for N=13, N=8 and N=193 checked against a bitwise schoolbook model.
- rst=1 asserted in S_O -> next cycle state=IDLE, out_valid=0, y=0, in_ready=1. No stale result emitted afterwards.
- N=2, a=2'b11, b=2'b10 -> y=3'b110. Covers the minimum width, H=1 and zero padding of the odd part.

Source files
------------

// File: rtl/oka_pkg.sv
// Shared types and helpers for the overlap-free Karatsuba GF(2) multiplier.
package oka_pkg;

  // Widest partial product spread() handles. 2*H-1 must not exceed this,
  // which covers operands up to N=512.
  localparam int OKA_MAXW = 512;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S_E  = 3'd1,
    S_O  = 3'd2,
    S_M  = 3'd3,
    DONE = 3'd4
  } oka_state_t;

  function automatic int oka_half(input int n);
    return (n + 1) / 2;
  endfunction

  // Interleave zeros: p[i] lands at bit 2i. Callers zero-extend narrower inputs.
  function automatic logic [2*OKA_MAXW-1:0] spread(input logic [OKA_MAXW-1:0] p);
    logic [2*OKA_MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < OKA_MAXW; i++) r[2*i] = p[i];
    return r;
  endfunction

endpackage

// File: rtl/gf2_poly_mul_comb.sv
// Combinational schoolbook carry-less multiplier, W x W -> 2W-1 bits.
module gf2_poly_mul_comb #(
  parameter int W = 7
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-2:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        p[i+j] = p[i+j] ^ (a[i] & b[j]);
  end

endmodule

// File: rtl/oka_seq_mult.sv
// Time-multiplexed overlap-free Karatsuba multiplier over GF(2)[x]:
// one half-width sub-multiplier issued for Pe, Po and Pm on consecutive cycles.
module oka_seq_mult
  import oka_pkg::*;
#(
  parameter int N = 13
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] y
);

  localparam int H  = oka_half(N);
  localparam int PW = 2*H - 1;
  localparam int YW = 2*N - 1;
  localparam int SW = 2*OKA_MAXW;

  oka_state_t state;

  logic [H-1:0]  ae, ao, be, bo;
  logic [H-1:0]  ae_d, ao_d, be_d, bo_d;
  logic [PW-1:0] pe, po;
  logic [H-1:0]  mul_a, mul_b;
  logic [PW-1:0] mul_p;
  logic [SW-1:0] full;

  // Even/odd coefficient split; the odd half is short by one bit for odd N
  // and stays zero-padded at the top.
  always_comb begin
    ae_d = '0;
    ao_d = '0;
    be_d = '0;
    bo_d = '0;
    for (int i = 0; i < N; i++) begin
      if (i % 2 == 0) begin
        ae_d[i/2] = a[i];
        be_d[i/2] = b[i];
      end else begin
        ao_d[i/2] = a[i];
        bo_d[i/2] = b[i];
      end
    end
  end

  always_comb begin
    mul_a = ae ^ ao;
    mul_b = be ^ bo;
    case (state)
      S_E: begin mul_a = ae; mul_b = be; end
      S_O: begin mul_a = ao; mul_b = bo; end
      default: ;
    endcase
  end

  gf2_poly_mul_comb #(.W(H)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // Recombination is only consumed in S_M, where mul_p is Pm.
  always_comb begin
    full = spread(OKA_MAXW'(pe))
         ^ (spread(OKA_MAXW'(po)) << 2)
         ^ (spread(OKA_MAXW'(mul_p ^ pe ^ po)) << 1);
  end

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      y         <= '0;
      ae        <= '0;
      ao        <= '0;
      be        <= '0;
      bo        <= '0;
      pe        <= '0;
      po        <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ae    <= ae_d;
          ao    <= ao_d;
          be    <= be_d;
          bo    <= bo_d;
          state <= S_E;
        end
        S_E: begin
          pe    <= mul_p;
          state <= S_O;
        end
        S_O: begin
          po    <= mul_p;
          state <= S_M;
        end
        S_M: begin
          y         <= full[YW-1:0];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          if (in_valid) begin
            ae    <= ae_d;
            ao    <= ao_d;
            be    <= be_d;
            bo    <= bo_d;
            state <= S_E;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Anything above the product width must be zero; for odd N this is the
  // x^(2N) term, which only the zero pad of the odd halves can feed.
  always_ff @(posedge clk) begin
    if (!rst && state == S_M) assert (full[SW-1:YW] == '0);
  end

endmodule

// File: tb/tb_oka_seq_mult.sv
// Scoreboard bench for oka_seq_mult at N = 13, 8, 193 and 2 in parallel.
module tb_oka_seq_mult;

  logic clk;
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic int n_of(input int i);
    case (i)
      0: return 13;
      1: return 8;
      2: return 193;
      default: return 2;
    endcase
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_inst
    localparam int NN = n_of(gi);

    logic            rst, in_valid, out_ready, bp_en;
    logic [NN-1:0]   a, b;
    logic            in_ready, out_valid;
    logic [2*NN-2:0] y;
    logic [2*NN-2:0] q[$];
    int              acc_cyc;

    oka_seq_mult #(.N(NN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y)
    );

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL N=%0d %s: got %0h expected %0h", NN, nm, act, exp);
      end
    endtask

    // Reference: textbook carry-less product, XOR of shifted copies of y.
    function automatic logic [2*NN-2:0] clmul(input logic [NN-1:0] x, input logic [NN-1:0] yv);
      logic [2*NN-2:0] r, ys;
      r  = '0;
      ys = {{(NN-1){1'b0}}, yv};
      for (int i = 0; i < NN; i++) if (x[i]) r = r ^ (ys << i);
      return r;
    endfunction

    function automatic logic [NN-1:0] rnd();
      logic [NN-1:0] r;
      for (int k = 0; k < NN; k++) r[k] = 1'($urandom_range(0, 1));
      return r;
    endfunction

    task automatic accept(input logic [NN-1:0] xa, input logic [NN-1:0] xb, input bit push);
      int t;
      in_valid = 1'b1;
      a = xa;
      b = xb;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("accept_ready", 512'(in_ready), 512'(1));
      if (push) q.push_back(clmul(xa, xb));
      acc_cyc = cyc;
      @(posedge clk);
      #1;
    endtask

    task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 400) begin
        @(posedge clk);
        t++;
      end
      chk("drain", 512'(q.size()), 512'(0));
      @(posedge clk);
      #1;
    endtask

    initial begin : monitor
      logic [2*NN-2:0] e;
      forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
          if (q.size() == 0) chk("spurious_out", 512'(out_valid), 512'(0));
          else begin
            e = q.pop_front();
            chk("y", 512'(y), 512'(e));
          end
        end
      end
    end

    initial forever begin
      @(posedge clk);
      #1;
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin : driver
      logic [NN-1:0] ones, top, one, two, three;
      logic [NN-1:0] da[4], db[4];
      logic [2*NN-2:0] e;
      int t, cnt, prev;
      ones = '1;
      top = '0;   top[NN-1] = 1'b1;
      one = '0;   one[0] = 1'b1;
      two = '0;   two[1] = 1'b1;
      three = '0; three[1:0] = 2'b11;
      da = '{three, ones, top, ones};
      db = '{three, ones, top, two};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; bp_en = 1'b0;
      a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 512'(out_valid), 512'(0));
      chk("rst_y", 512'(y), 512'(0));
      chk("rst_in_ready", 512'(in_ready), 512'(1));
      @(posedge clk); #1;
      rst = 1'b0;

      // 1*1 with latency and busy-state checks; in_valid kept high while busy
      accept(one, one, 1'b1);
      a = ones; b = ones;
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        chk("busy_in_ready", 512'(in_ready), 512'(0));
        chk("busy_out_valid", 512'(out_valid), 512'(0));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("latency_out_valid", 512'(out_valid), 512'(1));
      drain();

      for (int k = 0; k < 4; k++) begin
        accept(da[k], db[k], 1'b1);
        in_valid = 1'b0;
        drain();
      end

      // stall with operands toggling underneath
      out_ready = 1'b0;
      e = clmul(ones, one);
      accept(ones, one, 1'b1);
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("stall_reach", 512'(out_valid), 512'(1));
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        a = rnd(); b = rnd();
        @(negedge clk);
        chk("stall_y", 512'(y), 512'(e));
        chk("stall_valid", 512'(out_valid), 512'(1));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();

      // reset while in S_O: product dropped
      accept(rnd(), rnd(), 1'b0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_out_valid", 512'(out_valid), 512'(0));
      chk("midrst_y", 512'(y), 512'(0));
      chk("midrst_in_ready", 512'(in_ready), 512'(1));
      @(posedge clk); #1;
      rst = 1'b0;
      cnt = 0;
      repeat (10) begin
        @(negedge clk);
        if (out_valid) cnt++;
      end
      chk("no_stale", 512'(cnt), 512'(0));
      @(posedge clk); #1;

      // back-to-back through the fast path
      prev = 0;
      for (int i = 0; i < 1000; i++) begin
        accept(rnd(), rnd(), 1'b1);
        if (i > 0) chk("throughput", 512'(acc_cyc - prev), 512'(4));
        prev = acc_cyc;
      end
      in_valid = 1'b0;
      drain();

      // random backpressure and idle gaps
      bp_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
        accept(rnd(), rnd(), 1'b1);
      end
      in_valid = 1'b0;
      bp_en = 1'b0;
      out_ready = 1'b1;
      drain();

      done_cnt++;
    end
  end

  initial begin
    for (int t = 0; t < 40000 && done_cnt < 4; t++) @(posedge clk);
    if (done_cnt < 4) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got %0d finished instances expected 4", done_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
